sreg_bank: RTL and testbench

Parametrised bank of synchronous QBUS device registers on the FPGA internal I/O bus. It is the successor to the fixed two-register block and adds:
- a parametrised register count
- per-bit access modes (read/write, write-1-to-clear, read-only hardware value)
- QBUS byte writes (DATOB)
- per-bit reset values
- hardware set inputs
- one-shot read/write strobes, so device logic can react to CSR accesses

It sits between the I/O bus decoder and device controllers (RK/RL/TM-style CSR sets).

---
 rtl/qsic_io_pkg.sv | 13 +
 rtl/sreg_cell.sv | 34 +++
 rtl/sreg_bank.sv | 108 ++++++++++
 tb/tb_sreg_bank.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/qsic_io_pkg.sv
// Shared constants and helpers for QBUS internal I/O bus register blocks.
package qsic_io_pkg;
    localparam int REG_W    = 16;
    localparam int IOADDR_W = 13;

    typedef logic [1:0] lane_t;

    // Byte lane enables: word write hits both lanes, byte write picks by a0.
    function automatic lane_t lane_en(input logic iBYTE, input logic a0);
        if (!iBYTE) return 2'b11;
        return a0 ? 2'b10 : 2'b01;
    endfunction
endpackage

// File: rtl/sreg_cell.sv
// One 16-bit device register with per-bit RW / W1C / read-only behaviour.
module sreg_cell
    import qsic_io_pkg::*;
#(
    parameter logic [REG_W-1:0] RW_MASK   = '1,
    parameter logic [REG_W-1:0] W1C_MASK  = '0,
    parameter logic [REG_W-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wrEn,
    input  lane_t            laneEn,
    input  logic [REG_W-1:0] wdata,
    input  logic [REG_W-1:0] hwSet,
    output logic [REG_W-1:0] value
);
    localparam logic [REG_W-1:0] STORE_MASK = RW_MASK | W1C_MASK;

    logic [REG_W-1:0] bitEn;
    logic [REG_W-1:0] rwNext;
    logic [REG_W-1:0] w1cNext;

    always_comb begin
        bitEn   = {{(REG_W/2){laneEn[1]}}, {(REG_W/2){laneEn[0]}}} & {REG_W{wrEn}};
        rwNext  = (value & ~bitEn) | (wdata & bitEn);
        // hardware set is OR-ed in after the clear so a coincident event survives
        w1cNext = (value & ~(wdata & bitEn)) | hwSet;
    end

    always_ff @(posedge clk) begin
        if (reset) value <= RESET_VAL & STORE_MASK;
        else       value <= (rwNext & RW_MASK) | (w1cNext & W1C_MASK);
    end
endmodule

// File: rtl/sreg_bank.sv
// Parametrised bank of QBUS CSRs: address decode, read mux, byte lanes and
// one-shot access strobes around COUNT sreg_cell instances.
module sreg_bank
    import qsic_io_pkg::*;
#(
    parameter int                       COUNT     = 4,
    parameter logic [COUNT*REG_W-1:0]   RW_MASK   = '1,
    parameter logic [COUNT*REG_W-1:0]   W1C_MASK  = '0,
    parameter logic [COUNT*REG_W-1:0]   RESET_VAL = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [IOADDR_W-1:0]      addr_base,
    input  logic [IOADDR_W-1:0]      iADDR,
    input  logic                     iBS7,
    output logic                     iREAD_MATCH,
    output logic                     iWRITE_MATCH,
    input  logic [REG_W-1:0]         iWDATA,
    input  logic                     iWRITE,
    input  logic                     iBYTE,
    input  logic                     iREAD,
    output logic [REG_W-1:0]         iRDATA,
    input  logic [COUNT*REG_W-1:0]   hw_val,
    input  logic [COUNT*REG_W-1:0]   hw_set,
    output logic [COUNT*REG_W-1:0]   reg_out,
    output logic [COUNT-1:0]         wr_pulse,
    output logic [COUNT-1:0]         rd_pulse
);
    localparam int CBITS = $clog2(COUNT);
    localparam logic [COUNT*REG_W-1:0] STORE_MASK = RW_MASK | W1C_MASK;

    logic [CBITS-1:0] idx;
    logic             hit;
    logic             wrAcc, rdAcc, wrNew, rdNew;
    logic             wrPrev, rdPrev;
    logic [CBITS-1:0] wrPrevIdx, rdPrevIdx;
    logic [COUNT-1:0] sel;
    logic [REG_W-1:0] rdMux;
    logic [REG_W-1:0] laneData;
    lane_t            lanes;
    logic             unusedAddrBits;

    assign unusedAddrBits = ^addr_base[CBITS:0];

    assign idx = iADDR[CBITS:1];
    assign hit = iBS7 && (iADDR[IOADDR_W-1:CBITS+1] == addr_base[IOADDR_W-1:CBITS+1])
                 && (32'(idx) < COUNT);

    assign iREAD_MATCH  = hit && !iADDR[0];
    assign iWRITE_MATCH = hit && (!iADDR[0] || iBYTE);

    assign wrAcc = iWRITE && iWRITE_MATCH;
    assign rdAcc = iREAD && iREAD_MATCH;
    // a held strobe that moves to another register counts as a fresh access
    assign wrNew = wrAcc && (!wrPrev || wrPrevIdx != idx);
    assign rdNew = rdAcc && (!rdPrev || rdPrevIdx != idx);

    assign lanes    = lane_en(iBYTE, iADDR[0]);
    assign laneData = {iBYTE ? iWDATA[7:0] : iWDATA[15:8], iWDATA[7:0]};

    always_comb begin
        sel   = '0;
        rdMux = '0;
        for (int unsigned i = 0; i < COUNT; i++) begin
            if (32'(idx) == i) begin
                sel[i] = 1'b1;
                rdMux  = reg_out[i*REG_W +: REG_W]
                       | (hw_val[i*REG_W +: REG_W] & ~STORE_MASK[i*REG_W +: REG_W]);
            end
        end
    end

    assign iRDATA = iREAD_MATCH ? rdMux : {REG_W{1'bz}};

    for (genvar g = 0; g < COUNT; g++) begin : gCell
        sreg_cell #(
            .RW_MASK   (RW_MASK[g*REG_W +: REG_W]),
            .W1C_MASK  (W1C_MASK[g*REG_W +: REG_W]),
            .RESET_VAL (RESET_VAL[g*REG_W +: REG_W])
        ) uCell (
            .clk    (clk),
            .reset  (reset),
            .wrEn   (wrAcc && sel[g]),
            .laneEn (lanes),
            .wdata  (laneData),
            .hwSet  (hw_set[g*REG_W +: REG_W]),
            .value  (reg_out[g*REG_W +: REG_W])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_pulse  <= '0;
            rd_pulse  <= '0;
            wrPrev    <= 1'b0;
            rdPrev    <= 1'b0;
            wrPrevIdx <= '0;
            rdPrevIdx <= '0;
        end else begin
            wr_pulse  <= wrNew ? sel : '0;
            rd_pulse  <= rdNew ? sel : '0;
            wrPrev    <= wrAcc;
            rdPrev    <= rdAcc;
            wrPrevIdx <= idx;
            rdPrevIdx <= idx;
        end
    end
endmodule

// File: tb/tb_sreg_bank.sv
// Self-checking bench for sreg_bank: decode table, directed CSR sequences and
// randomized traffic against a per-bit behavioural model.
module tb_sreg_bank;
    localparam logic [12:0] BASE = 13'o17440;
    localparam logic [63:0] RWM  = {16'h0000, 16'hFFFF, 16'hFFFF, 16'h7FFF};
    localparam logic [63:0] W1CM = {48'h0, 16'h8000};
    localparam logic [63:0] RSTV = {16'h0000, 16'o000200, 16'h0000, 16'h0000};

    logic        clk, reset, reset3;
    logic [12:0] iADDR;
    logic        iBS7, iWRITE, iBYTE, iREAD;
    logic [15:0] iWDATA;
    logic [63:0] hw_val, hw_set, reg_out;
    logic [3:0]  wr_pulse, rd_pulse;
    logic        iREAD_MATCH, iWRITE_MATCH;
    wire  [15:0] rdata;

    logic        rm3, wm3;
    wire  [15:0] rdata3;
    logic [47:0] reg_out3;
    logic [2:0]  wp3, rp3;

    sreg_bank #(.COUNT(4), .RW_MASK(RWM), .W1C_MASK(W1CM), .RESET_VAL(RSTV)) dut (
        .clk(clk), .reset(reset), .addr_base(BASE), .iADDR(iADDR), .iBS7(iBS7),
        .iREAD_MATCH(iREAD_MATCH), .iWRITE_MATCH(iWRITE_MATCH), .iWDATA(iWDATA),
        .iWRITE(iWRITE), .iBYTE(iBYTE), .iREAD(iREAD), .iRDATA(rdata),
        .hw_val(hw_val), .hw_set(hw_set), .reg_out(reg_out),
        .wr_pulse(wr_pulse), .rd_pulse(rd_pulse)
    );

    sreg_bank #(.COUNT(3)) dut3 (
        .clk(clk), .reset(reset3), .addr_base(BASE), .iADDR(iADDR), .iBS7(iBS7),
        .iREAD_MATCH(rm3), .iWRITE_MATCH(wm3), .iWDATA(iWDATA),
        .iWRITE(iWRITE), .iBYTE(iBYTE), .iREAD(iREAD), .iRDATA(rdata3),
        .hw_val(48'h0), .hw_set(48'h0), .reg_out(reg_out3),
        .wr_pulse(wp3), .rd_pulse(rp3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int failed = 0;

    logic [15:0] m[4];
    logic [15:0] rwM[4];
    logic [15:0] w1cM[4];
    int lastWr = -1;
    int lastRd = -1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic checkZ(input string name, input logic [15:0] got);
        tests++;
        if (!(got === 16'hzzzz || got === 16'h0000)) begin
            failed++;
            $display("FAIL %s: got %0h expected undriven (z) at %0t", name, got, $time);
        end
    endtask

    task automatic setBus(input logic bs7, input logic [12:0] a, input logic byt,
                          input logic [15:0] d, input logic wr, input logic rd);
        @(negedge clk);
        iBS7 = bs7; iADDR = a; iBYTE = byt; iWDATA = d; iWRITE = wr; iREAD = rd;
        #1;
    endtask

    // Check combinational outputs, advance one edge, then check registered state.
    task automatic step();
        logic        hit, rm, wm, wacc, racc;
        int          k;
        logic [15:0] nm[4];
        logic [3:0]  ewp, erp;
        k   = (int'(iADDR) >> 1) & 3;
        hit = iBS7 && ((int'(iADDR) >> 3) == (int'(BASE) >> 3)) && k < 4;
        rm  = hit && !iADDR[0];
        wm  = hit && (!iADDR[0] || iBYTE);
        check("read_match", 64'(iREAD_MATCH), 64'(rm));
        check("write_match", 64'(iWRITE_MATCH), 64'(wm));
        if (rm) check("rdata", 64'(rdata), 64'(m[k] | (hw_val[k*16 +: 16] & ~(rwM[k] | w1cM[k]))));
        else    checkZ("rdata_z", rdata);
        wacc = iWRITE && wm;
        racc = iREAD && rm;
        for (int r = 0; r < 4; r++) begin
            for (int b = 0; b < 16; b++) begin
                logic en, d;
                en = wacc && r == k && (!iBYTE || (b / 8) == int'(iADDR[0]));
                d  = iBYTE ? iWDATA[b % 8] : iWDATA[b];
                if (rwM[r][b])       nm[r][b] = en ? d : m[r][b];
                else if (w1cM[r][b]) nm[r][b] = (m[r][b] && !(en && d)) || hw_set[r*16 + b];
                else                 nm[r][b] = 1'b0;
            end
        end
        ewp = (wacc && lastWr != k) ? 4'(1 << k) : 4'b0;
        erp = (racc && lastRd != k) ? 4'(1 << k) : 4'b0;
        lastWr = wacc ? k : -1;
        lastRd = racc ? k : -1;
        if (reset) begin
            for (int r = 0; r < 4; r++) nm[r] = RSTV[r*16 +: 16] & (rwM[r] | w1cM[r]);
            ewp = 4'b0; erp = 4'b0; lastWr = -1; lastRd = -1;
        end
        @(posedge clk);
        #1;
        for (int r = 0; r < 4; r++) m[r] = nm[r];
        check("reg_out", reg_out, {m[3], m[2], m[1], m[0]});
        check("wr_pulse", 64'(wr_pulse), 64'(ewp));
        check("rd_pulse", 64'(rd_pulse), 64'(erp));
    endtask

    typedef struct {
        logic        bs7;
        logic [12:0] addr;
        logic        byt;
        logic        rm, wm, rm3, wm3;
    } vec_t;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vecs[10];
        vecs[0] = '{1'b1, BASE,          1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[1] = '{1'b1, BASE + 13'd1,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b1, BASE + 13'd1,  1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{1'b1, BASE + 13'd6,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{1'b1, BASE + 13'd7,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{1'b1, BASE + 13'd4,  1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[6] = '{1'b1, BASE + 13'd8,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{1'b1, BASE - 13'd2,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{1'b0, BASE,          1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9] = '{1'b1, 13'o07440,     1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        for (int r = 0; r < 4; r++) begin
            rwM[r]  = RWM[r*16 +: 16];
            w1cM[r] = W1CM[r*16 +: 16];
            m[r]    = RSTV[r*16 +: 16] & (rwM[r] | w1cM[r]);
        end
        reset = 1'b1; reset3 = 1'b1;
        iBS7 = 1'b0; iADDR = '0; iBYTE = 1'b0; iWDATA = '0; iWRITE = 1'b0; iREAD = 1'b0;
        hw_set = '0;
        hw_val = {16'o000017, 48'h0};

        // reset state
        step(); step();
        check("rst_reg_out", reg_out, {16'h0, 16'o000200, 32'h0});
        check("rst_wr_pulse", 64'(wr_pulse), 64'h0);
        setBus(1'b1, BASE + 13'd4, 1'b0, 16'h0, 1'b0, 1'b1);
        reset = 1'b0;
        check("rst_read_reg2", 64'(rdata), 64'(16'o000200));
        step();
        setBus(1'b0, BASE, 1'b0, 16'h0, 1'b0, 1'b0);
        step();

        // word write held three cycles: one pulse
        setBus(1'b1, BASE + 13'd2, 1'b0, 16'o123456, 1'b1, 1'b0);
        step();
        check("word_wr_pulse", 64'(wr_pulse), 64'(4'b0010));
        check("word_reg1", 64'(reg_out[31:16]), 64'(16'o123456));
        step();
        check("held_wr_pulse", 64'(wr_pulse), 64'h0);
        step();
        check("held_wr_pulse2", 64'(wr_pulse), 64'h0);

        // byte write to the odd address lands in the high byte
        setBus(1'b1, BASE + 13'd2, 1'b0, 16'h0, 1'b1, 1'b0);
        step();
        setBus(1'b1, BASE + 13'd3, 1'b1, 16'o000377, 1'b1, 1'b0);
        step();
        check("byte_hi_reg1", 64'(reg_out[31:16]), 64'(16'o177400));
        setBus(1'b1, BASE + 13'd3, 1'b0, 16'hFFFF, 1'b1, 1'b0);
        check("odd_word_wmatch", 64'(iWRITE_MATCH), 64'h0);
        step();
        check("odd_word_nochg", 64'(reg_out[31:16]), 64'(16'o177400));

        // W1C bit 15 of reg0
        setBus(1'b0, BASE, 1'b0, 16'h0, 1'b0, 1'b0);
        hw_set = 64'h8000;
        step();
        hw_set = '0;
        check("w1c_set", 64'(reg_out[15]), 64'h1);
        setBus(1'b1, BASE, 1'b0, 16'o100000, 1'b1, 1'b0);
        step();
        check("w1c_clear", 64'(reg_out[15]), 64'h0);
        setBus(1'b0, BASE, 1'b0, 16'h0, 1'b0, 1'b0);
        hw_set = 64'h8000;
        step();
        setBus(1'b1, BASE, 1'b0, 16'o100000, 1'b1, 1'b0);
        step();
        hw_set = '0;
        check("w1c_set_wins", 64'(reg_out[15]), 64'h1);

        // read-only register 3
        setBus(1'b1, BASE + 13'd6, 1'b0, 16'h0, 1'b0, 1'b1);
        check("ro_read", 64'(rdata), 64'(16'o000017));
        step();
        check("rd_pulse_first", 64'(rd_pulse), 64'(4'b1000));
        step();
        check("rd_pulse_held", 64'(rd_pulse), 64'h0);
        step();
        setBus(1'b1, BASE + 13'd6, 1'b0, 16'hFFFF, 1'b1, 1'b0);
        step();
        check("ro_write_ignored", 64'(reg_out[63:48]), 64'h0);

        // strobe held across reset release pulses on the first edge after reset
        setBus(1'b1, BASE + 13'd2, 1'b0, 16'h1234, 1'b1, 1'b0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        check("post_reset_pulse", 64'(wr_pulse), 64'(4'b0010));

        // non-match cases
        setBus(1'b0, BASE, 1'b0, 16'hFFFF, 1'b1, 1'b1);
        step();
        setBus(1'b1, BASE + 13'd8, 1'b0, 16'hFFFF, 1'b1, 1'b1);
        step();
        setBus(1'b0, BASE, 1'b0, 16'h0, 1'b0, 1'b0);
        reset3 = 1'b0;
        step();
        setBus(1'b1, BASE + 13'd6, 1'b0, 16'hFFFF, 1'b1, 1'b1);
        checkZ("c3_oob_rdata", rdata3);
        step();
        check("c3_oob_reg_out", 64'(reg_out3), 64'h0);
        check("c3_oob_pulses", 64'({wp3, rp3}), 64'h0);
        setBus(1'b1, BASE + 13'd4, 1'b0, 16'hFFFF, 1'b1, 1'b0);
        step();
        check("c3_reg2_write", 64'(reg_out3), {16'h0, 16'hFFFF, 32'h0});
        check("c3_reg2_pulse", 64'(wp3), 64'(3'b100));
        setBus(1'b0, BASE, 1'b0, 16'h0, 1'b0, 1'b0);
        step();

        // decode table
        for (int i = 0; i < 10; i++) begin
            setBus(vecs[i].bs7, vecs[i].addr, vecs[i].byt, 16'h0, 1'b0, 1'b0);
            check("tbl_rmatch", 64'(iREAD_MATCH), 64'(vecs[i].rm));
            check("tbl_wmatch", 64'(iWRITE_MATCH), 64'(vecs[i].wm));
            check("tbl_rmatch3", 64'(rm3), 64'(vecs[i].rm3));
            check("tbl_wmatch3", 64'(wm3), 64'(vecs[i].wm3));
            if (!vecs[i].rm) checkZ("tbl_rdata_z", rdata);
        end
        setBus(1'b0, BASE, 1'b0, 16'h0, 1'b0, 1'b0);
        step();

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if ($urandom_range(0, 2) != 0) begin
                iBS7   = ($urandom_range(0, 7) != 0);
                iADDR  = ($urandom_range(0, 5) == 0) ? 13'($urandom) : BASE + 13'($urandom_range(0, 9));
                iBYTE  = 1'($urandom);
                iWRITE = 1'($urandom);
                iREAD  = 1'($urandom);
            end
            iWDATA = 16'($urandom);
            hw_val = {$urandom, $urandom};
            hw_set = {$urandom & $urandom & $urandom, $urandom & $urandom & $urandom};
            reset  = ($urandom_range(0, 49) == 0);
            #1;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
